// File: rtl/pwm_mmio_pkg.sv
// Shared definitions for the memory-mapped PWM block: store-size encodings,
// register offsets and the byte-lane merge used for partial stores.
package pwm_mmio_pkg;

    typedef enum logic [2:0] {
        MEM_SB = 3'b000,
        MEM_SH = 3'b001,
        MEM_SW = 3'b010
    } mem_size_e;

    localparam logic [31:0] PWM_CTRL   = 32'h00;
    localparam logic [31:0] PWM_PERIOD = 32'h04;
    localparam logic [31:0] PWM_DUTY0  = 32'h08;

    // STATUS sits directly after the last DUTY register, so it moves with the channel count.
    function automatic logic [31:0] pwm_status_off(input int num_ch);
        return PWM_DUTY0 + 32'(4 * num_ch);
    endfunction

    typedef struct packed {
        logic        ok;
        logic [31:0] data;
    } merge_t;

    function automatic merge_t lane_merge(input logic [31:0] old_val,
                                          input logic [31:0] wdata,
                                          input logic [2:0]  funct3,
                                          input logic [1:0]  lane);
        merge_t r;
        r.ok   = 1'b0;
        r.data = old_val;
        case (mem_size_e'(funct3))
            MEM_SB: begin
                r.ok = 1'b1;
                r.data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            MEM_SH: begin
                if (!lane[0]) begin
                    r.ok = 1'b1;
                    r.data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                end
            end
            MEM_SW: begin
                if (lane == 2'b00) begin
                    r.ok   = 1'b1;
                    r.data = wdata;
                end
            end
            default: r.ok = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (shadow + active), comparator and output flop.
module pwm_channel #(
    parameter int PWM_BITS   = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                duty_we,
    input  logic [PWM_BITS:0]   duty_wdata,
    input  logic                load_active,
    input  logic [PWM_BITS-1:0] counter,
    input  logic                enable,
    output logic [PWM_BITS:0]   duty_shadow,
    output logic                pwm_out
);

    logic [PWM_BITS:0] shadow_q, shadow_d;
    logic [PWM_BITS:0] active_q, active_d;
    logic              pwm_q, pwm_d;

    always_comb begin
        shadow_d = duty_we ? duty_wdata : shadow_q;
        // A wrap takes the pre-write shadow; while stopped, active follows every write.
        if (load_active)   active_d = shadow_q;
        else if (!enable)  active_d = shadow_d;
        else               active_d = active_q;
        pwm_d = (enable && ({1'b0, counter} < active_q)) ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= ACTIVE_LOW;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign duty_shadow = shadow_q;
    assign pwm_out     = pwm_q;

endmodule

// File: rtl/pwm_mmio.sv
// Memory-mapped N-channel PWM peripheral: bus decode, CTRL/PERIOD registers,
// prescaler, shared period counter and registered read mux.
module pwm_mmio
    import pwm_mmio_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          PWM_BITS   = 8,
    parameter int          PRE_BITS   = 16,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              wr_en,
    input  logic [2:0]        funct3,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              hit,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              wrap_pulse
);

    localparam logic [31:0] WIN_BYTES  = 32'(4 * (NUM_CH + 3));
    localparam logic [31:0] STATUS_OFF = pwm_status_off(NUM_CH);

    logic                en_q, en_d;
    logic [PRE_BITS-1:0] pre_val_q, pre_val_d;
    logic [PRE_BITS-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] period_q, period_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                wrap_q, wrap_d;
    logic                hit_q, hit_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]       offset, word_off, cur_img;
    logic              in_win, wr_ok, tick, wrap, run;
    merge_t            merged;
    logic [NUM_CH-1:0] duty_we;
    logic [PWM_BITS:0] duty_shadow [NUM_CH];
    logic              unused_merge;

    // Register image at the addressed word; shared by the read mux and the store merge.
    always_comb begin
        offset   = addr - BASE_ADDR;
        in_win   = offset < WIN_BYTES;
        word_off = {offset[31:2], 2'b00};
        cur_img  = '0;
        if (word_off == PWM_CTRL) begin
            cur_img[0]               = en_q;
            cur_img[16 +: PRE_BITS]  = pre_val_q;
        end else if (word_off == PWM_PERIOD) begin
            cur_img[PWM_BITS-1:0] = period_q;
        end else if (word_off == STATUS_OFF) begin
            cur_img[PWM_BITS-1:0] = cnt_q;
            cur_img[31]           = en_q;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (word_off == PWM_DUTY0 + 32'(4 * i)) cur_img[PWM_BITS:0] = duty_shadow[i];
        end
        merged = lane_merge(cur_img, wdata, funct3, offset[1:0]);
        wr_ok  = wr_en && in_win && merged.ok;
    end

    always_comb begin
        en_d      = en_q;
        pre_val_d = pre_val_q;
        period_d  = period_q;
        if (wr_ok && word_off == PWM_CTRL) begin
            en_d      = merged.data[0];
            pre_val_d = merged.data[16 +: PRE_BITS];
        end
        if (wr_ok && word_off == PWM_PERIOD) period_d = merged.data[PWM_BITS-1:0];
        for (int i = 0; i < NUM_CH; i++) begin
            duty_we[i] = wr_ok && (word_off == PWM_DUTY0 + 32'(4 * i));
        end

        // >= keeps both counters sane when a smaller limit is written mid-count.
        tick = en_q && (pre_cnt_q >= pre_val_q);
        wrap = tick && (cnt_q >= period_q);
        run  = en_q && en_d;

        if (!en_q || !en_d || tick) pre_cnt_d = '0;
        else                        pre_cnt_d = pre_cnt_q + PRE_BITS'(1);

        if (!en_d || wrap) cnt_d = '0;
        else if (tick)     cnt_d = cnt_q + PWM_BITS'(1);
        else               cnt_d = cnt_q;

        wrap_d  = wrap;
        hit_d   = in_win;
        rdata_d = in_win ? cur_img : '0;
    end

    assign unused_merge = ^merged.data;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q      <= 1'b0;
            pre_val_q <= '0;
            pre_cnt_q <= '0;
            period_q  <= '1;
            cnt_q     <= '0;
            wrap_q    <= 1'b0;
            hit_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            en_q      <= en_d;
            pre_val_q <= pre_val_d;
            pre_cnt_q <= pre_cnt_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
            hit_q     <= hit_d;
            rdata_q   <= rdata_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(
            .PWM_BITS   (PWM_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .duty_we     (duty_we[g]),
            .duty_wdata  (merged.data[PWM_BITS:0]),
            .load_active (wrap),
            .counter     (cnt_q),
            .enable      (run),
            .duty_shadow (duty_shadow[g]),
            .pwm_out     (pwm_out[g])
        );
    end

    assign rdata      = rdata_q;
    assign hit        = hit_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_pwm_mmio.sv
// Self-checking bench for pwm_mmio: register reads and per-period PWM windows
// are compared against expectations queued when the stimulus is applied.
module tb_pwm_mmio;
    import pwm_mmio_pkg::*;

    localparam int          NUM_CH   = 4;
    localparam int          PWM_BITS = 8;
    localparam logic [31:0] BASE     = 32'hFFFF_FF00;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_PERIOD = BASE + 32'h04;
    localparam logic [31:0] A_DUTY0  = BASE + 32'h08;
    localparam logic [31:0] A_DUTY1  = BASE + 32'h0C;
    localparam logic [31:0] A_DUTY2  = BASE + 32'h10;
    localparam logic [31:0] A_DUTY3  = BASE + 32'h14;
    localparam logic [31:0] A_STATUS = BASE + 32'h18;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       addr;
    logic              wr_en;
    logic [2:0]        funct3;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              hit;
    logic [NUM_CH-1:0] pwm_out;
    logic              wrap_pulse;

    pwm_mmio #(
        .NUM_CH     (NUM_CH),
        .PWM_BITS   (PWM_BITS),
        .PRE_BITS   (16),
        .BASE_ADDR  (BASE),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wr_en      (wr_en),
        .funct3     (funct3),
        .wdata      (wdata),
        .rdata      (rdata),
        .hit        (hit),
        .pwm_out    (pwm_out),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One PWM window = the clocks from one wrap_pulse up to the next, with per-channel low counts.
    typedef struct packed {
        logic [15:0]       clocks;
        logic [3:0][15:0]  low;
    } win_t;

    typedef struct packed {
        logic [31:0] exp;
        logic [31:0] mask;
        logic        hit;
    } rd_t;

    win_t win_q[$];
    rd_t  rd_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_win(input int clocks, input int l0, input int l1, input int l2, input int l3);
        win_t w;
        w.clocks = 16'(clocks);
        w.low[0] = 16'(l0);
        w.low[1] = 16'(l1);
        w.low[2] = 16'(l2);
        w.low[3] = 16'(l3);
        win_q.push_back(w);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        addr   = a;
        wdata  = d;
        funct3 = f3;
        wr_en  = 1'b1;
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp,
                            input logic [31:0] mask, input logic exp_hit);
        rd_t r;
        addr  = a;
        wr_en = 1'b0;
        rd_q.push_back('{exp: exp, mask: mask, hit: exp_hit});
        tick();
        r = rd_q.pop_front();
        check({tag, "_data"}, rdata & r.mask, r.exp & r.mask);
        check({tag, "_hit"}, 32'(hit), 32'(r.hit));
    endtask

    task automatic wait_wrap(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!wrap_pulse && n < 200);
        if (!wrap_pulse) check({tag, "_wrap_timeout"}, 32'(wrap_pulse), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (win_q.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, 32'(win_q.size()), 32'd0);
    endtask

    // Window monitor: closes a window at every wrap_pulse and scores it if an expectation is queued.
    initial begin : mon
        win_t got;
        win_t exp;
        bit   started;
        started = 1'b0;
        got     = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                started = 1'b0;
                got     = '0;
            end else begin
                if (wrap_pulse) begin
                    if (started && win_q.size() > 0) begin
                        exp = win_q.pop_front();
                        check("win_clocks", 32'(got.clocks), 32'(exp.clocks));
                        for (int i = 0; i < NUM_CH; i++)
                            check($sformatf("win_low%0d", i), 32'(got.low[i]), 32'(exp.low[i]));
                    end
                    started = 1'b1;
                    got     = '0;
                end
                got.clocks = got.clocks + 16'd1;
                for (int i = 0; i < NUM_CH; i++)
                    if (!pwm_out[i]) got.low[i] = got.low[i] + 16'd1;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        // Reset must override a store in the same cycle.
        reset  = 1'b1;
        addr   = A_CTRL;
        wdata  = 32'h0000_0001;
        funct3 = MEM_SW;
        wr_en  = 1'b1;
        repeat (3) tick();
        wr_en  = 1'b0;
        reset  = 1'b0;
        check("rst_pwm_out", 32'(pwm_out), 32'h0000_000F);
        check("rst_wrap", 32'(wrap_pulse), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        bus_read("rst_ctrl", A_CTRL, 32'h0, '1, 1'b1);
        bus_read("rst_period", A_PERIOD, 32'h0000_00FF, '1, 1'b1);
        bus_read("rst_duty0", A_DUTY0, 32'h0, '1, 1'b1);
        bus_read("rst_status", A_STATUS, 32'h0, '1, 1'b1);
        bus_read("oow_above", BASE + 32'h1C, 32'h0, '1, 1'b0);
        bus_read("oow_below", BASE - 32'h4, 32'h0, '1, 1'b0);

        // PERIOD=3, DUTY0=2; DUTY1=0 never low, DUTY2=4 and DUTY3=0x1FF always low.
        bus_write(A_PERIOD, 32'd3, MEM_SW);
        bus_write(A_DUTY0, 32'd2, MEM_SW);
        bus_write(A_DUTY2, 32'd4, MEM_SW);
        bus_write(A_DUTY3, 32'h1FF, MEM_SW);
        bus_write(A_CTRL, 32'd1, MEM_SW);
        wait_wrap("t2");
        tick();
        push_win(4, 2, 0, 4, 4);
        push_win(4, 2, 0, 4, 4);
        drain("t2");

        // DUTY0=1 written while the counter is 1: this period keeps 2 low, later ones have 1.
        wait_wrap("t3");
        tick();
        push_win(4, 2, 0, 4, 4);
        push_win(4, 1, 0, 4, 4);
        push_win(4, 1, 0, 4, 4);
        bus_write(A_DUTY0, 32'd1, MEM_SW);
        bus_read("t3_duty0", A_DUTY0, 32'd1, '1, 1'b1);
        drain("t3");

        // SB into CTRL byte 2 sets prescale 4: one tick per 5 clocks, 20-clock period.
        bus_write(BASE + 32'h2, 32'h0000_0004, MEM_SB);
        bus_read("t4_ctrl", A_CTRL, 32'h0004_0001, '1, 1'b1);
        wait_wrap("t4");
        tick();
        push_win(20, 5, 0, 20, 20);
        push_win(20, 5, 0, 20, 20);
        drain("t4");

        // Disable mid-period, then re-enable and time the first wrap.
        bus_write(A_CTRL, 32'd1, MEM_SW);
        wait_wrap("t6");
        tick();
        tick();
        bus_write(A_CTRL, 32'd0, MEM_SW);
        check("t6_off_pwm", 32'(pwm_out), 32'h0000_000F);
        bus_read("t6_status", A_STATUS, 32'h0, '1, 1'b1);
        repeat (3) begin
            tick();
            check("t6_idle", {27'd0, wrap_pulse, pwm_out}, 32'h0000_000F);
        end
        bus_write(A_CTRL, 32'd1, MEM_SW);
        n = 0;
        while (!wrap_pulse && n < 50) begin
            tick();
            n++;
        end
        check("t6_first_wrap_ticks", 32'(n), 32'd4);

        // Store-size and alignment corner cases.
        bus_write(BASE + 32'h9, 32'h0000_00FF, MEM_SH);
        bus_read("sh_odd_duty0", A_DUTY0, 32'd1, '1, 1'b1);
        bus_write(BASE + 32'h6, 32'h0000_0055, MEM_SW);
        bus_read("sw_misalign_period", A_PERIOD, 32'd3, '1, 1'b1);
        bus_write(BASE + 32'h6, 32'h0000_ABCD, MEM_SH);
        bus_read("sh_upper_period", A_PERIOD, 32'd3, '1, 1'b1);
        bus_write(A_PERIOD, 32'h0000_1234, MEM_SH);
        bus_read("sh_lower_period", A_PERIOD, 32'h34, '1, 1'b1);
        bus_write(A_PERIOD, 32'd3, MEM_SW);
        bus_write(A_DUTY1, 32'h0000_0055, 3'b100);
        bus_read("bad_funct3_duty1", A_DUTY1, 32'd0, '1, 1'b1);
        bus_write(BASE + 32'hD, 32'h0000_0001, MEM_SB);
        bus_read("sb_lane1_duty1", A_DUTY1, 32'h100, '1, 1'b1);
        bus_write(A_DUTY1, 32'hFFFF_FFFF, MEM_SW);
        bus_read("trunc_duty1", A_DUTY1, 32'h1FF, '1, 1'b1);
        bus_write(A_STATUS, 32'h0, MEM_SW);
        bus_read("status_ro_en", A_STATUS, 32'h8000_0000, 32'h8000_0000, 1'b1);
        bus_read("ctrl_after_status_wr", A_CTRL, 32'h1, '1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
